ram_burst_master: RTL and testbench

//  Initiator for the single-port synchronous RAM: drives write port (we/addr/data) and read port (addr/q).

---
 rtl/ram_burst_master.sv | 182 ++++++++++++++++++
 tb/tb_ram_burst_master.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM.
// Accepts burst commands, streams write beats into the RAM and read
// beats out of it, hiding the RAM's 1-cycle read latency behind a
// 2-entry read FIFO.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cmd_*           burst command (write flag, start address, beats-1)
//   wr_*            write beat stream (valid/ready)
//   rd_*            read beat stream (valid/ready)
//   done            1-cycle pulse after the last beat of a burst
//   ram_*           RAM write port (we/addr/data) and read port (addr/q)
module ram_burst_master #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          ram_we,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_write_addr,
    output logic [AW-1:0] ram_read_addr,
    input  logic [DW-1:0] ram_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] len_q, len_d;
    // Beats written (WRITE) or issued to the RAM (READ); AW+1 bits
    // so a full 2**AW-beat burst can be counted.
    logic [AW:0]   beat_q, beat_d;
    logic [AW:0]   popped_q, popped_d;
    logic          inflight_q, inflight_d;
    logic          done_q, done_d;

    logic [DW-1:0] fifo_mem_q [2];
    logic          fifo_wp_q, fifo_wp_d;
    logic          fifo_rp_q, fifo_rp_d;
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;

    logic          push;
    logic          pop;
    logic          issue;
    logic [AW:0]   total;
    logic [2:0]    occ;

    assign total = {1'b0, len_q} + {{AW{1'b0}}, 1'b1};
    assign push  = (state_q == S_READ) && inflight_q;
    assign pop   = (fifo_cnt_q != 2'd0) && rd_ready;

    // Slots that will be occupied after this edge, counting the read
    // already in flight; a new issue is allowed only if one is free.
    assign occ = {1'b0, fifo_cnt_q}
               + {2'b00, inflight_q}
               - {2'b00, pop};

    assign issue = (state_q == S_READ)
                && (beat_q < total)
                && (occ < 3'd2);

    assign rd_valid       = (fifo_cnt_q != 2'd0);
    assign rd_data        = fifo_mem_q[fifo_rp_q];
    assign done           = done_q;
    assign ram_data       = wr_data;
    assign ram_write_addr = addr_q;
    assign ram_read_addr  = addr_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        popped_d   = popped_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        ram_we     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    len_d    = cmd_len;
                    beat_d   = '0;
                    popped_d = '0;
                    state_d  = cmd_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                wr_ready = 1'b1;
                ram_we   = wr_valid;
                if (wr_valid) begin
                    addr_d = addr_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == {1'b0, len_q}) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_READ: begin
                inflight_d = issue;
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                end
                if (pop) begin
                    popped_d = popped_q + 1'b1;
                    if (popped_q == {1'b0, len_q}) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_wp_d  = fifo_wp_q ^ push;
        fifo_rp_d  = fifo_rp_q ^ pop;
        fifo_cnt_d = fifo_cnt_q
                   + {1'b0, push}
                   - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            popped_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            fifo_wp_q  <= 1'b0;
            fifo_rp_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            popped_q   <= popped_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            fifo_wp_q  <= fifo_wp_d;
            fifo_rp_q  <= fifo_rp_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: the count gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[fifo_wp_q] <= ram_q;
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master.
// Uses a behavioural RAM and a shadow memory as reference.
module tb_ram_burst_master;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int N  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          ram_we;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_write_addr;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_q;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int we_cnt   = 0;

    logic [DW-1:0] ram    [N];
    logic [DW-1:0] shadow [N];
    logic [DW-1:0] wbuf   [N];

    always #5 clk = ~clk;

    ram_burst_master #(.DW(DW), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .done           (done),
        .ram_we         (ram_we),
        .ram_data       (ram_data),
        .ram_write_addr (ram_write_addr),
        .ram_read_addr  (ram_read_addr),
        .ram_q          (ram_q)
    );

    // Behavioural synchronous RAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) ram[ram_write_addr] <= ram_data;
        ram_q <= ram[ram_read_addr];
    end

    always @(posedge clk) if (ram_we === 1'b1) we_cnt++;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b1;
        wr_data   = 8'h55;
        rd_ready  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
        end
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_wr_ready got=%b exp=0", wr_ready);
        end
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_valid got=%b exp=0", rd_valid);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        checks++;
        if (ram_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_ram_we got=%b exp=0", ram_we);
        end
        checks++;
        if (ram_write_addr !== 6'd0) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=0", ram_write_addr);
        end
        @(negedge clk);
        rst      = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (ram_we !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_reset we=%b rdy=%b exp 0/1",
                     ram_we, cmd_ready);
        end
    endtask

    task automatic do_write(input int addr, input int len,
                            input bit gaps);
        int d0;
        int w0;
        int i;
        int t;
        d0 = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = addr[AW-1:0];
        cmd_len   = len[AW-1:0];
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_cmd_ready got=%b exp=1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_len   = AW'($urandom);
        w0 = we_cnt;
        i  = 0;
        t  = 0;
        while (i <= len && t < 2000) begin
            wr_valid = gaps ? (($urandom % 3) != 0) : 1'b1;
            wr_data  = wbuf[i];
            #1;
            checks++;
            if (wr_ready !== 1'b1 || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL wr_handshake wr_ready=%b cmd_ready=%b exp 1/0",
                         wr_ready, cmd_ready);
            end
            checks++;
            if (ram_we !== wr_valid) begin
                failures++;
                $display("FAIL wr_ram_we got=%b exp=%b", ram_we, wr_valid);
            end
            if (wr_valid) begin
                checks++;
                if (ram_write_addr !== AW'((addr + i) % N)
                    || ram_data !== wbuf[i]) begin
                    failures++;
                    $display("FAIL wr_beat%0d addr=%h data=%h exp %h/%h",
                             i, ram_write_addr, ram_data,
                             (addr + i) % N, wbuf[i]);
                end
                shadow[(addr + i) % N] = wbuf[i];
                i++;
            end
            @(negedge clk);
            t++;
        end
        wr_valid = 1'b0;
        checks++;
        if (t >= 2000) begin
            failures++;
            $display("FAIL wr_timeout beats=%0d exp=%0d", i, len + 1);
        end
        #1;
        checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_done done=%b cmd_ready=%b exp 1/1",
                     done, cmd_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL wr_done_pulse got=%b exp=0", done);
        end
        checks++;
        if (done_cnt - d0 != 1 || we_cnt - w0 != len + 1) begin
            failures++;
            $display("FAIL wr_counts done=%0d we=%0d exp 1/%0d",
                     done_cnt - d0, we_cnt - w0, len + 1);
        end
    endtask

    // mode 0: rd_ready=1, mode 1: 1,0,0 repeating, mode 2: random
    task automatic do_read(input int addr, input int len,
                           input int mode, input bit chk_lat);
        int d0;
        int k;
        int t;
        int pc;
        int first;
        d0    = done_cnt;
        k     = 0;
        t     = 0;
        pc    = 0;
        first = -1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = addr[AW-1:0];
        cmd_len   = len[AW-1:0];
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rd_cmd_ready got=%b exp=1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_len   = AW'($urandom);
        while (k <= len && t < 4000) begin
            t++;
            if (mode == 0)      rd_ready = 1'b1;
            else if (mode == 1) rd_ready = ((pc % 3) == 0);
            else                rd_ready = 1'($urandom);
            pc++;
            wr_valid = 1'($urandom);
            wr_data  = 8'($urandom);
            #1;
            checks++;
            if (ram_we !== 1'b0 || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL rd_ctrl ram_we=%b cmd_ready=%b exp 0/0",
                         ram_we, cmd_ready);
            end
            if (rd_valid === 1'b1 && first < 0) first = t;
            if (rd_valid === 1'b1 && rd_ready) begin
                checks++;
                if (rd_data !== shadow[(addr + k) % N]) begin
                    failures++;
                    $display("FAIL rd_beat%0d got=%h exp=%h",
                             k, rd_data, shadow[(addr + k) % N]);
                end
                if (mode == 0) begin
                    checks++;
                    if (t != first + k) begin
                        failures++;
                        $display("FAIL rd_rate beat%0d cycle=%0d exp=%0d",
                                 k, t, first + k);
                    end
                end
                k++;
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        wr_valid = 1'b0;
        checks++;
        if (t >= 4000) begin
            failures++;
            $display("FAIL rd_timeout beats=%0d exp=%0d", k, len + 1);
        end
        if (chk_lat) begin
            checks++;
            if (first != 3) begin
                failures++;
                $display("FAIL rd_latency got=%0d exp=3", first);
            end
        end
        #1;
        checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_done done=%b cmd_ready=%b rd_valid=%b exp 1/1/0",
                     done, cmd_ready, rd_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL rd_done_pulse done=%b pulses=%0d exp 0/1",
                     done, done_cnt - d0);
        end
    endtask

    task automatic test_write_basic();
        for (int i = 0; i < 4; i++) wbuf[i] = 8'hA0 + 8'(i);
        do_write(16, 3, 1'b0);
        checks++;
        if (ram[16] !== 8'hA0 || ram[19] !== 8'hA3) begin
            failures++;
            $display("FAIL wr_ram_content got=%h,%h exp=a0,a3",
                     ram[16], ram[19]);
        end
    endtask

    task automatic test_read_basic();
        do_read(16, 3, 0, 1'b1);
    endtask

    task automatic test_backpressure();
        do_read(16, 3, 1, 1'b1);
        do_read(16, 3, 2, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
        do_write(62, 3, 1'b1);
        checks++;
        if (ram[62] !== 8'd1 || ram[63] !== 8'd2
            || ram[0] !== 8'd3 || ram[1] !== 8'd4) begin
            failures++;
            $display("FAIL wrap_content got=%h %h %h %h exp=01 02 03 04",
                     ram[62], ram[63], ram[0], ram[1]);
        end
        do_read(62, 3, 1, 1'b0);
    endtask

    task automatic test_full_length();
        int bad;
        for (int i = 0; i < N; i++) wbuf[i] = 8'(i) ^ 8'h5A;
        do_write(0, N - 1, 1'b0);
        bad = 0;
        for (int i = 0; i < N; i++)
            if (ram[i] !== (8'(i) ^ 8'h5A)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL full_content bad_words=%0d exp=0", bad);
        end
        do_read(0, N - 1, 0, 1'b1);
        do_read(0, N - 1, 2, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        int d0;
        int k;
        int t;
        d0 = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 6'd0;
        cmd_len   = 6'd15;
        @(negedge clk);
        cmd_valid = 1'b0;
        rd_ready  = 1'b1;
        k = 0;
        t = 0;
        while (k < 2 && t < 50) begin
            #1;
            if (rd_valid === 1'b1) begin
                checks++;
                if (rd_data !== shadow[k]) begin
                    failures++;
                    $display("FAIL rst_pre_beat%0d got=%h exp=%h",
                             k, rd_data, shadow[k]);
                end
                k++;
            end
            @(negedge clk);
            t++;
        end
        rst      = 1'b1;
        wr_valid = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1
            || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid rd_valid=%b done=%b cmd_ready=%b we=%b exp 0/0/1/0",
                     rd_valid, done, cmd_ready, ram_we);
        end
        @(negedge clk);
        rst      = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_done pulses=%0d rd_valid=%b exp 0/0",
                     done_cnt - d0, rd_valid);
        end
        do_read(0, 5, 0, 1'b1);
    endtask

    task automatic test_random();
        int a;
        int l;
        wbuf[0] = 8'hC3;
        do_write(32, 0, 1'b0);
        do_read(32, 0, 0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            a = $urandom_range(0, N - 1);
            l = $urandom_range(0, 15);
            for (int i = 0; i <= l; i++) wbuf[i] = 8'($urandom);
            do_write(a, l, 1'b1);
            do_read(a, l, 2, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_backpressure();
        test_wrap();
        test_full_length();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
